// File: rtl/mem_arb_pkg.sv
// Shared types and sizing for the I/D main-memory arbiter.
package mem_arb_pkg;

  localparam int DEF_LINE_ADDR_LEN = 3;
  localparam int DEF_ADDR_W        = 32;
  localparam int BEATS             = 1 << DEF_LINE_ADDR_LEN;

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: on a tie the side not served last wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_e last_owner,
  output owner_e owner,
  output logic   any
);

  always_comb begin
    owner = OWN_I;
    any   = req_i | req_d;
    if (req_i && req_d) begin
      owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
    end else if (req_d) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the I- and D-cache line engines,
// one line burst at a time, with round-robin ownership.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LINE_ADDR_LEN = DEF_LINE_ADDR_LEN,
  parameter int ADDR_W        = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ic_req,
  input  logic [ADDR_W-1:0]        ic_addr,
  output logic [31:0]              ic_rdata,
  output logic                     ic_rvalid,
  output logic                     ic_done,
  input  logic                     dc_req,
  input  logic                     dc_we,
  input  logic [ADDR_W-1:0]        dc_addr,
  input  logic [31:0]              dc_wdata,
  output logic [LINE_ADDR_LEN-1:0] dc_beat,
  output logic [31:0]              dc_rdata,
  output logic                     dc_rvalid,
  output logic                     dc_done,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic                     mem_ack,
  input  logic [31:0]              mem_rdata,
  output logic [31:0]              grant_cnt_i,
  output logic [31:0]              grant_cnt_d
);

  localparam int LINE_W = ADDR_W - LINE_ADDR_LEN - 2;

  state_e                   state_q, state_d;
  owner_e                   owner_q, owner_d;
  owner_e                   last_owner_q, last_owner_d;
  owner_e                   pick_owner;
  logic                     pick_any;
  logic                     we_q, we_d;
  logic [LINE_W-1:0]        line_q, line_d;
  logic [LINE_ADDR_LEN-1:0] beat_q, beat_d;
  logic [31:0]              cnt_i_q, cnt_i_d;
  logic [31:0]              cnt_d_q, cnt_d_d;

  // Word-within-line and byte offsets come from the beat counter instead.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_addr[LINE_ADDR_LEN+1:0], dc_addr[LINE_ADDR_LEN+1:0]};

  mem_arb_rr u_rr (
    .req_i      (ic_req),
    .req_d      (dc_req),
    .last_owner (last_owner_q),
    .owner      (pick_owner),
    .any        (pick_any)
  );

  assign grant_cnt_i = cnt_i_q;
  assign grant_cnt_d = cnt_d_q;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    line_d       = line_q;
    beat_d       = beat_q;
    cnt_i_d      = cnt_i_q;
    cnt_d_d      = cnt_d_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    ic_rdata     = '0;
    ic_rvalid    = 1'b0;
    ic_done      = 1'b0;
    dc_rdata     = '0;
    dc_rvalid    = 1'b0;
    dc_done      = 1'b0;
    dc_beat      = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          owner_d = pick_owner;
          if (pick_owner == OWN_D) begin
            line_d = dc_addr[ADDR_W-1:LINE_ADDR_LEN+2];
            we_d   = dc_we;
          end else begin
            line_d = ic_addr[ADDR_W-1:LINE_ADDR_LEN+2];
            we_d   = 1'b0;
          end
          beat_d  = '0;
          state_d = BURST;
        end
      end

      BURST: begin
        mem_req  = 1'b1;
        mem_we   = we_q;
        mem_addr = {line_q, beat_q, 2'b00};
        if (owner_q == OWN_D) begin
          mem_wdata = dc_wdata;
          dc_beat   = beat_q;
        end
        // A stalled beat simply repeats; only an ack moves the burst forward.
        if (mem_ack) begin
          if (owner_q == OWN_D) begin
            dc_rvalid = !we_q;
            dc_rdata  = mem_rdata;
          end else begin
            ic_rvalid = !we_q;
            ic_rdata  = mem_rdata;
          end
          beat_d = beat_q + 1'b1;
          if (beat_q == '1) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        if (owner_q == OWN_D) begin
          dc_done = 1'b1;
          cnt_d_d = cnt_d_q + 32'd1;
        end else begin
          ic_done = 1'b1;
          cnt_i_d = cnt_i_q + 32'd1;
        end
        last_owner_d = owner_q;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_I;
      last_owner_q <= OWN_I;
      we_q         <= 1'b0;
      line_q       <= '0;
      beat_q       <= '0;
      cnt_i_q      <= '0;
      cnt_d_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      line_q       <= line_d;
      beat_q       <= beat_d;
      cnt_i_q      <= cnt_i_d;
      cnt_d_q      <= cnt_d_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: refill, stalled writeback, tie-breaking,
// mid-burst withdrawal and asynchronous reset mid-burst.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;
  logic        ic_done;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [2:0]  dc_beat;
  logic [31:0] dc_rdata;
  logic        dc_rvalid;
  logic        dc_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] grant_cnt_i;
  logic [31:0] grant_cnt_d;

  int n_checks = 0;
  int n_errors = 0;
  int burst_cyc, nwr, bad_rv, got_done, ndone, rv, dn, mr, done_at;
  int own_seq [4];
  int done_cyc [4];

  always #5 clk = ~clk;

  // D-side write data answers the beat index; memory read data is a fixed scramble of the address.
  assign dc_wdata  = 32'hA000_0000 + 32'(dc_beat);
  assign mem_rdata = mem_addr ^ 32'h5A5A_0000;

  mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ic_req      (ic_req),
    .ic_addr     (ic_addr),
    .ic_rdata    (ic_rdata),
    .ic_rvalid   (ic_rvalid),
    .ic_done     (ic_done),
    .dc_req      (dc_req),
    .dc_we       (dc_we),
    .dc_addr     (dc_addr),
    .dc_wdata    (dc_wdata),
    .dc_beat     (dc_beat),
    .dc_rdata    (dc_rdata),
    .dc_rvalid   (dc_rvalid),
    .dc_done     (dc_done),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .grant_cnt_i (grant_cnt_i),
    .grant_cnt_d (grant_cnt_d)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n   = 1'b0;
    ic_req  = 1'b0;
    ic_addr = '0;
    dc_req  = 1'b0;
    dc_we   = 1'b0;
    dc_addr = '0;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_cnt_i", grant_cnt_i, 32'd0);
    check("rst_cnt_d", grant_cnt_d, 32'd0);
    check("rst_dc_beat", 32'(dc_beat), 32'd0);
    rst_n = 1'b1;

    // Single I refill with ack always high.
    tick;
    ic_req  = 1'b1;
    ic_addr = 32'h0000_1234;
    mem_ack = 1'b1;
    sample;
    check("t1_no_req_cycle0", 32'(mem_req), 32'd0);
    for (int b = 0; b < BEATS; b++) begin
      tick;
      sample;
      check("t1_mem_req", 32'(mem_req), 32'd1);
      check("t1_mem_addr", mem_addr, 32'h1220 + 32'(4 * b));
      check("t1_ic_rvalid", 32'(ic_rvalid), 32'd1);
      check("t1_ic_rdata", ic_rdata, (32'h1220 + 32'(4 * b)) ^ 32'h5A5A_0000);
      check("t1_dc_rvalid", 32'(dc_rvalid), 32'd0);
    end
    tick;
    sample;
    check("t1_ic_done", 32'(ic_done), 32'd1);
    check("t1_req_in_done", 32'(mem_req), 32'd0);
    tick;
    ic_req = 1'b0;
    sample;
    check("t1_cnt_i", grant_cnt_i, 32'd1);
    check("t1_done_once", 32'(ic_done), 32'd0);
    $display("txn: I refill 0x1234 -> cnt_i=%0d", grant_cnt_i);

    // D writeback, ack low on every other cycle.
    tick;
    dc_req  = 1'b1;
    dc_we   = 1'b1;
    dc_addr = 32'h0000_4000;
    mem_ack = 1'b0;
    burst_cyc = 0; nwr = 0; bad_rv = 0; got_done = 0;
    for (int c = 1; c <= 40 && got_done == 0; c++) begin
      tick;
      mem_ack = (c % 2 == 0);
      sample;
      if (mem_req) burst_cyc++;
      if (ic_rvalid || dc_rvalid) bad_rv++;
      if (mem_req && mem_ack && nwr < 8) begin
        check("t2_mem_we", 32'(mem_we), 32'd1);
        check("t2_wdata", mem_wdata, 32'hA000_0000 + 32'(nwr));
        check("t2_addr", mem_addr, 32'h4000 + 32'(4 * nwr));
        nwr++;
      end
      if (dc_done) got_done = 1;
    end
    check("t2_done_seen", 32'(got_done), 32'd1);
    check("t2_burst_cycles", 32'(burst_cyc), 32'd16);
    check("t2_writes", 32'(nwr), 32'd8);
    check("t2_no_rvalid", 32'(bad_rv), 32'd0);
    tick;
    dc_req  = 1'b0;
    dc_we   = 1'b0;
    mem_ack = 1'b1;
    sample;
    check("t2_cnt_d", grant_cnt_d, 32'd1);
    $display("txn: D writeback 0x4000 -> %0d writes, %0d burst cycles", nwr, burst_cyc);

    // Both requesters from reset, held: D, I, D, I with one IDLE cycle between bursts.
    tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    ic_req  = 1'b1;
    ic_addr = 32'h0000_0100;
    dc_req  = 1'b1;
    dc_addr = 32'h0000_0200;
    ndone = 0;
    for (int c = 1; c <= 60 && ndone < 4; c++) begin
      tick;
      sample;
      if (ic_done || dc_done) begin
        own_seq[ndone]  = dc_done ? 1 : 0;
        done_cyc[ndone] = c;
        ndone++;
      end
    end
    check("t3_ndone", 32'(ndone), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check("t3_owner", 32'(own_seq[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("t3_done_cycle", 32'(done_cyc[k]), 32'(9 + 10 * k));
    end
    tick;
    ic_req = 1'b0;
    dc_req = 1'b0;
    sample;
    check("t3_cnt_i", grant_cnt_i, 32'd2);
    check("t3_cnt_d", grant_cnt_d, 32'd2);
    $display("txn: tie from reset -> owners %0d %0d %0d %0d (1=D)", own_seq[0], own_seq[1], own_seq[2], own_seq[3]);

    // I request dropped at beat 3: burst completes, no regrant.
    tick;
    ic_req  = 1'b1;
    ic_addr = 32'h0000_2000;
    rv = 0; dn = 0; mr = 0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (c == 4) ic_req = 1'b0;
      sample;
      if (ic_rvalid) rv++;
      if (ic_done) dn++;
      if (mem_req) mr++;
    end
    check("t4_beats", 32'(rv), 32'd8);
    check("t4_done_once", 32'(dn), 32'd1);
    check("t4_no_regrant", 32'(mr), 32'd8);
    check("t4_cnt_i", grant_cnt_i, 32'd3);
    $display("txn: I withdrawn at beat 3 -> %0d beats, %0d done", rv, dn);

    // Asynchronous reset during beat 5 of a D refill.
    tick;
    dc_req  = 1'b1;
    dc_we   = 1'b0;
    dc_addr = 32'h0000_6000;
    for (int c = 1; c <= 6; c++) tick;
    #1;
    check("t5_beat5", 32'(dc_beat), 32'd5);
    check("t5_rvalid_pre", 32'(dc_rvalid), 32'd1);
    rst_n  = 1'b0;
    dc_req = 1'b0;
    #1;
    check("t5_async_mem_req", 32'(mem_req), 32'd0);
    check("t5_async_beat", 32'(dc_beat), 32'd0);
    check("t5_async_rvalid", 32'(dc_rvalid), 32'd0);
    check("t5_async_cnt_i", grant_cnt_i, 32'd0);
    dn = 0;
    for (int c = 0; c < 3; c++) begin
      tick;
      sample;
      if (dc_done) dn++;
    end
    check("t5_no_dc_done", 32'(dn), 32'd0);
    tick;
    rst_n = 1'b1;
    tick;
    ic_req  = 1'b1;
    ic_addr = 32'h0000_8004;
    tick;
    sample;
    check("t5_beat0_addr", mem_addr, 32'h0000_8000);
    check("t5_beat0_rvalid", 32'(ic_rvalid), 32'd1);
    done_at = 0;
    for (int c = 2; c <= 20 && done_at == 0; c++) begin
      tick;
      sample;
      if (dc_done) dn++;
      if (ic_done) done_at = c;
    end
    check("t5_ic_done_cycle", 32'(done_at), 32'd9);
    check("t5_still_no_dc_done", 32'(dn), 32'd0);
    tick;
    ic_req = 1'b0;
    sample;
    check("t5_cnt_i", grant_cnt_i, 32'd1);
    check("t5_cnt_d", grant_cnt_d, 32'd0);
    $display("txn: reset mid D refill, then I refill 0x8004 -> done at cycle %0d", done_at);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter and burst sequencer that shares the single main-memory port between the instruction-cache and data-cache line refill/writeback engines. It sits between both cache controllers and the main-memory model. It grants one line transfer at a time using round-robin. It walks the line's word beats against the memory handshake and returns per-beat data and a completion pulse to the owner.

## Interface
- LINE_ADDR_LEN, 3: log2 of words per line; a burst is 2^LINE_ADDR_LEN beats.
- ADDR_W, 32: byte-address width.

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ic_req  in  1  I-side line-read request; held until ic_done
- ic_addr  in  ADDR_W  I-side byte address; low LINE_ADDR_LEN+2 bits ignored
- ic_rdata  out  32  beat read data
- ic_rvalid  out  1  ic_rdata valid this cycle
- ic_done  out  1  one-cycle burst-complete pulse
- dc_req  in  1  D-side line request; held until dc_done
- dc_we  in  1  1 = line writeback, 0 = line refill; sampled at grant
- dc_addr  in  ADDR_W  D-side byte address
- dc_wdata  in  32  write word for beat dc_beat; combinational response to dc_beat
- dc_beat  out  LINE_ADDR_LEN  current beat index while D owns the port
- dc_rdata  out  32  beat read data
- dc_rvalid  out  1  dc_rdata valid
- dc_done  out  1  one-cycle burst-complete pulse
- mem_req  out  1  beat request
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  word-aligned beat address
- mem_wdata  out  32  write data
- mem_ack  in  1  beat accepted; for reads, mem_rdata valid same cycle
- mem_rdata  in  32  read data
- grant_cnt_i  out  32  completed I bursts
- grant_cnt_d  out  32  completed D bursts

## Operation
- FSM with states IDLE, BURST, and DONE.
- IDLE:
  - If any request is pending, pick an owner, latch line address, latch we (I is always 0), clear beat, and go to BURST.
  - If both request, the requester not served last wins.
  - last_owner resets to I, so D wins the first tie.
- BURST:
  - mem_req = 1.
  - mem_addr = {line_addr[ADDR_W-1:LINE_ADDR_LEN+2], beat, 2'b00}.
  - mem_we = latched we.
  - mem_wdata = dc_wdata when D owns the port, else 0.
  - On mem_ack:
    - Owner's rvalid = !we and owner's rdata = mem_rdata.
    - beat increments.
    - On the last beat (all ones), go to DONE.
  - Without mem_ack, hold all outputs and the beat.
- DONE:
  - Owner's done = 1.
  - Increment the owner's grant counter (wraps at 2^32).
  - Update last_owner.
  - Go to IDLE.
- Requester inputs are ignored outside IDLE. Deasserting req mid-burst does not abort the burst. A req still high during the DONE cycle is ignored.
- The non-owner's rvalid, done, and beat stay 0 throughout.

## Timing
- Reset (asynchronous, any state, including mid-burst):
  - State = IDLE, beat = 0, last_owner = I.
  - All outputs = 0, including the counters.
  - The burst is abandoned with no done pulse.
- Request at cycle 0 in IDLE gives mem_req at cycle 1.
- With mem_ack held high, beats occupy cycles 1..2^LINE_ADDR_LEN, done is at cycle 2^LINE_ADDR_LEN+1, and IDLE is at the next cycle. Default burst = 10 cycles total.
- There is at least one IDLE cycle between consecutive bursts. The next grant is evaluated in that IDLE cycle.
- rdata and rvalid are combinational from mem_rdata and mem_ack. The next stage registers them.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, BURST, DONE}
  - owner enum {OWN_I, OWN_D}
  - localparam BEATS = 1<<LINE_ADDR_LEN
- Sub-module mem_arb_rr: 2-way round-robin picker (req_i, req_d, last_owner → owner, any).
- Everything else lives in mem_arbiter.

## Test plan
- **Single I refill, ack always 1:**
  - Stimulus: ic_req, ic_addr=0x0000_1234.
  - mem_addr must be 0x1220, 0x1224 … 0x123C over cycles 1–8.
  - ic_rvalid must be high for 8 cycles.
  - ic_done must pulse at cycle 9.
  - grant_cnt_i must be 1.
- **D writeback with ack stalls:**
  - Stimulus: dc_we=1, dc_wdata=0xA000_0000+dc_beat, mem_ack low on every other cycle.
  - Memory must see 8 writes, data 0xA000_0000..0xA000_0007 in order.
  - dc_done must arrive after 16 burst cycles.
  - dc_rvalid must never assert.
- **Simultaneous requests from reset, both held:**
  - Grant order must be D, I, D, I.
  - Each burst must be separated by exactly one IDLE cycle.
- **I request withdrawn at beat 3:**
  - The burst must still complete all 8 beats, with ic_done pulsed once.
  - No new grant may follow.
- **rst_n low during beat 5 of a D refill:**
  - Everything must be 0 immediately (asynchronously), with no dc_done.
  - After release, a new ic_req must be served starting at beat 0.
